// File: rtl/t01_bus_arbiter_pkg.sv
// t01_arb_pkg: shared state type and bus widths for the t01 bus arbiter.
package t01_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
    localparam int BUS_W = 32;
    localparam int SEL_W = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/t01_bus_arbiter_if.sv
// t01_bus_arbiter_if: the single Wishbone manager port shared by all requesters.
interface t01_bus_arbiter_if;
    import t01_arb_pkg::*;
    logic             read_i;
    logic             write_i;
    logic [BUS_W-1:0] adr_i;
    logic [BUS_W-1:0] cpu_dat_i;
    logic [SEL_W-1:0] sel_i;
    logic             busy_o;
    logic [BUS_W-1:0] cpu_dat_o;
    modport master (output read_i, write_i, adr_i, cpu_dat_i, sel_i, input busy_o, cpu_dat_o);
    modport slave (input read_i, write_i, adr_i, cpu_dat_i, sel_i, output busy_o, cpu_dat_o);
endinterface

// File: rtl/t01_rr_picker.sv
// t01_rr_picker: combinational round-robin pick of the first eligible slot at or after ptr_i.
module t01_rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0]         elig_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [N-1:0]         win_o,
    output logic                 valid_o
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] j;
    assign valid_o = |elig_i;
    // scan farthest-first so the slot nearest ptr_i overwrites the rest
    always_comb begin
        win_o = '0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = PW'((int'(ptr_i) + i) % N);
            if (elig_i[j]) win_o = N'(1) << j;
        end
    end
endmodule

// File: rtl/t01_bus_arbiter.sv
// t01_bus_arbiter: round-robin share of one Wishbone manager port among NUM_REQ requesters.
// Define T01_ARB_TIMEOUT_EN to build the busy_o watchdog that ends a stuck WAIT with req_err.
module t01_bus_arbiter
    import t01_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_read,
    input  logic [NUM_REQ-1:0]       req_write,
    input  logic [BUS_W*NUM_REQ-1:0] req_adr,
    input  logic [BUS_W*NUM_REQ-1:0] req_dat,
    input  logic [SEL_W*NUM_REQ-1:0] req_sel,
    output logic [NUM_REQ-1:0]       req_done,
    output logic [BUS_W-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]       req_err,
    output logic [NUM_REQ-1:0]       grant,
    t01_bus_arbiter_if.master        bus
);
    localparam int PW = $clog2(NUM_REQ);
    arb_state_t         state_q;
    logic [PW-1:0]      rr_ptr_q, idx_q, win_idx, nxt_ptr;
    logic [NUM_REQ-1:0] grant_q, done_q, err_q, elig, win;
    logic               win_valid, rd_q, read_q, write_q, tmo;
    logic [BUS_W-1:0]   rdata_q, adr_q, dat_q;
    logic [SEL_W-1:0]   sel_q;
    logic [BUS_W-1:0]   adr_a [NUM_REQ];
    logic [BUS_W-1:0]   dat_a [NUM_REQ];
    logic [SEL_W-1:0]   sel_a [NUM_REQ];
    for (genvar s = 0; s < NUM_REQ; s++) begin : g_slot
        assign adr_a[s] = req_adr[BUS_W*s +: BUS_W];
        assign dat_a[s] = req_dat[BUS_W*s +: BUS_W];
        assign sel_a[s] = req_sel[SEL_W*s +: SEL_W];
    end
    // masking with done_q stops the just-served requester from winning again on its done cycle
    assign elig = (req_read | req_write) & ~done_q;
    t01_rr_picker #(.N(NUM_REQ)) u_pick (.elig_i(elig), .ptr_i(rr_ptr_q), .win_o(win), .valid_o(win_valid));
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) if (win[i]) win_idx = PW'(i);
    end
    assign nxt_ptr = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
`ifdef T01_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;
    assign tmo = bus.busy_o && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign tmo = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            rd_q     <= 1'b0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            adr_q    <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
`ifdef T01_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            case (state_q)
                IDLE: if (win_valid) begin
                    state_q <= ISSUE;
                    grant_q <= win;
                    idx_q   <= win_idx;
                    rd_q    <= req_read[win_idx];
                    read_q  <= req_read[win_idx];
                    write_q <= ~req_read[win_idx];
                    adr_q   <= adr_a[win_idx];
                    dat_q   <= dat_a[win_idx];
                    sel_q   <= sel_a[win_idx];
                end
                ISSUE: begin
                    state_q <= WAIT;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
`ifdef T01_ARB_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: begin
`ifdef T01_ARB_TIMEOUT_EN
                    if (bus.busy_o) cnt_q <= cnt_q + 16'd1;
`endif
                    if (!bus.busy_o || tmo) begin
                        done_q   <= bus.busy_o ? '0 : grant_q;
                        err_q    <= bus.busy_o ? grant_q : '0;
                        rdata_q  <= (rd_q && !bus.busy_o) ? bus.cpu_dat_o : '0;
                        adr_q    <= '0;
                        dat_q    <= '0;
                        sel_q    <= '0;
                        grant_q  <= '0;
                        rr_ptr_q <= nxt_ptr;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign grant         = grant_q;
    assign req_done      = done_q;
    assign req_err       = err_q;
    assign req_rdata     = rdata_q;
    assign bus.read_i    = read_q;
    assign bus.write_i   = write_q;
    assign bus.adr_i     = adr_q;
    assign bus.cpu_dat_i = dat_q;
    assign bus.sel_i     = sel_q;
endmodule
